booth_seq_arbiter: RTL and testbench

Iterative radix-2 Booth multiplier controller that runs one signed Booth step per clock on a single shared add/sub/shift datapath. The datapath is shared between two requesters through a round-robin arbiter with a req/gnt handshake. It is the sequential counterpart of the combinational Booth multiplier and sits between the tile I/O decode and the result register bank.

---
 rtl/booth_seq_arbiter.sv | 97 +++++++++
 tb/tb_booth_seq_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/booth_seq_arbiter.sv
// booth_seq_arbiter: iterative radix-2 Booth multiplier, one step per cycle,
// shared between two requesters by a round-robin req/gnt arbiter.
module booth_seq_arbiter #(
   parameter int N  = 4,
   parameter int CW = 3
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           req0,
   input  logic [N-1:0]   x0,
   input  logic [N-1:0]   y0,
   input  logic           req1,
   input  logic [N-1:0]   x1,
   input  logic [N-1:0]   y1,
   input  logic           abort,
   output logic           gnt0,
   output logic           gnt1,
   output logic           busy,
   output logic           done,
   output logic           done_id,
   output logic [2*N-1:0] z
);
   localparam logic [1:0] S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2;
   logic [1:0]     state_q, state_d;
   logic [N:0]     a_q, a_d, m_q, m_d, sum;
   logic [N-1:0]   q_q, q_d;
   logic           q1_q, q1_d, last_q, last_d, own_q, own_d, idle;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [2*N-1:0] z_q, z_d, prod;
   assign idle    = state_q == S_IDLE;
   assign gnt0    = idle & req0 & (~req1 | last_q);
   assign gnt1    = idle & req1 & (~req0 | ~last_q);
   assign busy    = ~idle;
   assign prod    = {a_q[N-1:0], q_q};
   assign done    = (state_q == S_DONE) & ~abort;
   assign done_id = done & own_q;
   // the fresh product is visible in the DONE cycle itself; z_q keeps it afterwards
   assign z       = done ? prod : z_q;
   always_comb begin
      sum     = (q_q[0] & ~q1_q) ? a_q - m_q : (~q_q[0] & q1_q) ? a_q + m_q : a_q;
      state_d = state_q;
      a_d     = a_q;
      m_d     = m_q;
      q_d     = q_q;
      q1_d    = q1_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      own_d   = own_q;
      z_d     = z_q;
      if (idle) begin
         if (gnt0 | gnt1) begin
            state_d = S_CALC;
            a_d     = '0;
            m_d     = gnt1 ? {y1[N-1], y1} : {y0[N-1], y0};
            q_d     = gnt1 ? x1 : x0;
            q1_d    = 1'b0;
            cnt_d   = '0;
            last_d  = gnt1;
            own_d   = gnt1;
         end
      end else if (abort) begin
         state_d = S_IDLE;
      end else if (state_q == S_CALC) begin
         a_d     = {sum[N], sum[N:1]};
         q_d     = {sum[0], q_q[N-1:1]};
         q1_d    = q_q[0];
         cnt_d   = cnt_q + CW'(1);
         state_d = (cnt_q == CW'(N-1)) ? S_DONE : S_CALC;
      end else begin
         state_d = S_IDLE;
         z_d     = prod;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         m_q     <= '0;
         q_q     <= '0;
         q1_q    <= 1'b0;
         cnt_q   <= '0;
         last_q  <= 1'b1;
         own_q   <= 1'b0;
         z_q     <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         m_q     <= m_d;
         q_q     <= q_d;
         q1_q    <= q1_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         own_q   <= own_d;
         z_q     <= z_d;
      end
   end
endmodule

// File: tb/tb_booth_seq_arbiter.sv
// tb_booth_seq_arbiter: randomized self-checking bench against a signed-arithmetic reference.
module tb_booth_seq_arbiter;
   localparam int N = 4;
   logic clk = 1'b0, rst = 1'b1;
   logic req0 = 1'b0, req1 = 1'b0, abort = 1'b0;
   logic [N-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
   logic gnt0, gnt1, busy, done, done_id;
   logic [2*N-1:0] z;
   int n_chk = 0, n_fail = 0;
   bit last_srv = 1'b1;
   logic [2*N-1:0] last_z = '0;
   always #5 clk = ~clk;
   booth_seq_arbiter #(.N(N), .CW(3)) dut (
      .clk(clk), .rst(rst), .req0(req0), .x0(x0), .y0(y0), .req1(req1), .x1(x1), .y1(y1),
      .abort(abort), .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done), .done_id(done_id), .z(z)
   );
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask
   function automatic logic [2*N-1:0] mul(input logic [N-1:0] a, input logic [N-1:0] b);
      int p;
      p = int'($signed(a)) * int'($signed(b));
      return p[2*N-1:0];
   endfunction
   task automatic run_op(input bit r0, input bit r1, input logic [N-1:0] a0, input logic [N-1:0] b0,
                         input logic [N-1:0] a1, input logic [N-1:0] b1, input string tag);
      bit eid, seen;
      int c;
      logic [2*N-1:0] ez;
      eid = (r0 && r1) ? !last_srv : r1;
      ez  = eid ? mul(a1, b1) : mul(a0, b0);
      @(posedge clk); #1;
      req0 = r0; req1 = r1; x0 = a0; y0 = b0; x1 = a1; y1 = b1;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = gnt0 | gnt1;
      end
      check({tag, "_gnt"}, {30'd0, gnt1, gnt0}, eid ? 32'd2 : 32'd1);
      last_srv = eid;
      @(posedge clk); #1;
      req0 = 1'b0; req1 = 1'b0;
      x0 = N'($urandom_range(15)); y0 = N'($urandom_range(15));
      x1 = N'($urandom_range(15)); y1 = N'($urandom_range(15));
      c = 0;
      do begin
         @(negedge clk);
         c++;
         check({tag, "_busy"}, busy, 1);
         check({tag, "_nognt"}, gnt0 | gnt1, 0);
      end while (!done && c < N + 6);
      check({tag, "_lat"}, c, N + 1);
      check({tag, "_id"}, done_id, eid);
      check({tag, "_z"}, z, ez);
      last_z = ez;
   endtask
   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int gq[$];
      int ng, nd, lastg, o, mode;
      logic [N-1:0] a, b;
      #2;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_gnt", {gnt1, gnt0}, 0);
      check("rst_z", z, 0);
      check("rst_id", done_id, 0);
      #10 rst = 1'b0;
      run_op(1, 0, 4'd3, 4'hE, 4'd0, 4'd0, "first");
      run_op(0, 1, 4'd0, 4'd0, 4'h8, 4'h8, "c_m8m8");
      run_op(0, 1, 4'd0, 4'd0, 4'h8, 4'h7, "c_m8p7");
      run_op(0, 1, 4'd0, 4'd0, 4'h7, 4'h7, "c_p7p7");
      run_op(0, 1, 4'd0, 4'd0, 4'h0, 4'hB, "c_zero");
      // both requesters held continuously: expect strict alternation
      ng = 0; nd = 0; lastg = -1;
      @(posedge clk); #1;
      req0 = 1'b1; req1 = 1'b1; x0 = 4'd3; y0 = 4'd5; x1 = 4'hD; y1 = 4'd2;
      for (int c = 0; c < 80 && nd < 4; c++) begin
         @(negedge clk);
         if (gnt0 | gnt1) begin
            check("tie_gnt", {30'd0, gnt1, gnt0}, last_srv ? 32'd1 : 32'd2);
            if (lastg >= 0) check("tie_gap", c - lastg, N + 2);
            lastg = c;
            last_srv = !last_srv;
            gq.push_back(int'(last_srv));
            ng++;
         end
         if (done) begin
            o = (gq.size() > 0) ? gq.pop_front() : -1;
            check("tie_id", done_id, o);
            last_z = (o == 1) ? mul(4'hD, 4'd2) : mul(4'd3, 4'd5);
            check("tie_z", z, last_z);
            nd++;
         end
         @(posedge clk); #1;
         if (ng >= 4) begin req0 = 1'b0; req1 = 1'b0; end
      end
      check("tie_ngnt", ng, 4);
      check("tie_ndone", nd, 4);
      @(posedge clk); #1;
      req0 = 1'b1; x0 = 4'd5; y0 = 4'd3;
      @(negedge clk);
      check("ab_gnt", gnt0, 1);
      last_srv = 1'b0;
      @(posedge clk); #1; req0 = 1'b0;
      @(posedge clk); #1; abort = 1'b1;
      @(posedge clk); #1; abort = 1'b0;
      @(negedge clk);
      check("ab_idle", busy, 0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("ab_nodone", done, 0);
         check("ab_z", z, last_z);
      end
      run_op(1, 1, 4'd1, 4'd1, 4'd2, 4'd2, "ab_next");
      @(posedge clk); #1;
      req0 = 1'b1; x0 = 4'd5; y0 = 4'd5;
      @(negedge clk);
      check("ar_gnt", gnt0, 1);
      @(posedge clk); #1; req0 = 1'b0;
      @(posedge clk); #3; rst = 1'b1;
      #1;
      check("ar_busy", busy, 0);
      check("ar_done", done, 0);
      check("ar_z", z, 0);
      check("ar_id", done_id, 0);
      check("ar_gnt0", {gnt1, gnt0}, 0);
      #2 rst = 1'b0;
      last_srv = 1'b1;
      last_z = '0;
      run_op(1, 0, 4'd2, 4'd3, 4'd0, 4'd0, "ar_op");
      for (int i = 0; i < 256; i++) begin
         a = N'(i >> 4);
         b = N'(i);
         mode = int'($urandom_range(2));
         if (mode == 0) run_op(1, 0, a, b, N'($urandom_range(15)), N'($urandom_range(15)), "sw0");
         else if (mode == 1) run_op(0, 1, N'($urandom_range(15)), N'($urandom_range(15)), a, b, "sw1");
         else run_op(1, 1, a, b, a, b, "sw01");
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
